// File: rtl/ipv4_hdr_gen.sv
// ipv4_hdr_gen: builds a 20-byte IPv4 header (no options) from a one-cycle start request.
// The header checksum is computed over 10 cycles, then the bytes are streamed out
// under out_ready flow control.
// Optional feature: define IPV4_IDENT_INC_EN to make the identification field an
// incrementing 16-bit counter; otherwise it is a constant 0x0000.

// BYTE_LEN normally comes from params.vh; the fallback keeps this file self-contained.
`ifndef BYTE_LEN
`define BYTE_LEN 8
`endif

module ipv4_hdr_gen #(
    parameter int unsigned TTL   = 64,
    parameter int unsigned PROTO = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          src_ip,
    input  logic [31:0]          dst_ip,
    input  logic [15:0]          payload_len,
    input  logic                 out_ready,
    output logic [`BYTE_LEN-1:0] out,
    output logic                 outclk,
    output logic                 busy,
    output logic                 done
);

    localparam logic [7:0] TtlByte   = 8'(TTL);
    localparam logic [7:0] ProtoByte = 8'(PROTO);

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t      state;
    logic [31:0] src_q;
    logic [31:0] dst_q;
    logic [15:0] total_len_q;
    logic [16:0] acc;        // bit 16 is always 0 after the end-around fold
    logic [4:0]  idx;        // CALC word index, then EMIT byte index
    logic [15:0] ident;

`ifdef IPV4_IDENT_INC_EN
    logic [15:0] ident_cnt;
    logic [15:0] ident_q;
    assign ident = ident_q;
`else
    assign ident = 16'h0000;
`endif

    logic [15:0] calc_word;
    logic [16:0] acc_sum;
    logic [16:0] acc_fold;
    logic [15:0] csum;
    logic [7:0]  hdr_byte;

    // Header word added in the current CALC cycle; word 5 is the checksum slot, taken as 0.
    always_comb begin
        calc_word = 16'h0000;
        case (idx)
            5'd0:    calc_word = 16'h4500;
            5'd1:    calc_word = total_len_q;
            5'd2:    calc_word = ident;
            5'd3:    calc_word = 16'h4000;
            5'd4:    calc_word = {TtlByte, ProtoByte};
            5'd6:    calc_word = src_q[31:16];
            5'd7:    calc_word = src_q[15:0];
            5'd8:    calc_word = dst_q[31:16];
            5'd9:    calc_word = dst_q[15:0];
            default: calc_word = 16'h0000;
        endcase
    end

    // One's-complement add with the carry folded back in on the same cycle.
    always_comb begin
        acc_sum  = {1'b0, acc[15:0]} + {1'b0, calc_word};
        acc_fold = {1'b0, acc_sum[15:0] + {15'd0, acc_sum[16]}};
        csum     = ~acc[15:0];
    end

    // Byte currently offered in EMIT; the accumulator is stable there so csum is final.
    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            5'd0:    hdr_byte = 8'h45;
            5'd1:    hdr_byte = 8'h00;
            5'd2:    hdr_byte = total_len_q[15:8];
            5'd3:    hdr_byte = total_len_q[7:0];
            5'd4:    hdr_byte = ident[15:8];
            5'd5:    hdr_byte = ident[7:0];
            5'd6:    hdr_byte = 8'h40;
            5'd7:    hdr_byte = 8'h00;
            5'd8:    hdr_byte = TtlByte;
            5'd9:    hdr_byte = ProtoByte;
            5'd10:   hdr_byte = csum[15:8];
            5'd11:   hdr_byte = csum[7:0];
            5'd12:   hdr_byte = src_q[31:24];
            5'd13:   hdr_byte = src_q[23:16];
            5'd14:   hdr_byte = src_q[15:8];
            5'd15:   hdr_byte = src_q[7:0];
            5'd16:   hdr_byte = dst_q[31:24];
            5'd17:   hdr_byte = dst_q[23:16];
            5'd18:   hdr_byte = dst_q[15:8];
            5'd19:   hdr_byte = dst_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    // Output decode: bytes only appear in EMIT, and a transfer is exactly EMIT with out_ready.
    always_comb begin
        out    = (state == EMIT) ? hdr_byte : '0;
        outclk = (state == EMIT) && out_ready;
        busy   = (state != IDLE);
    end

    // Control FSM: latch request, accumulate checksum, stream bytes, pulse done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            src_q       <= 32'd0;
            dst_q       <= 32'd0;
            total_len_q <= 16'd0;
            acc         <= 17'd0;
            idx         <= 5'd0;
            done        <= 1'b0;
`ifdef IPV4_IDENT_INC_EN
            ident_cnt   <= 16'd0;
            ident_q     <= 16'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q       <= src_ip;
                        dst_q       <= dst_ip;
                        total_len_q <= payload_len + 16'd20;
`ifdef IPV4_IDENT_INC_EN
                        ident_q     <= ident_cnt;
`endif
                        acc         <= 17'd0;
                        idx         <= 5'd0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_fold;
                    if (idx == 5'd9) begin
                        idx   <= 5'd0;
                        state <= EMIT;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (idx == 5'd19) begin
                            idx   <= 5'd0;
                            done  <= 1'b1;
                            state <= IDLE;
`ifdef IPV4_IDENT_INC_EN
                            // Bump now so a start in the done cycle sees the new value.
                            ident_cnt <= ident_cnt + 16'd1;
`endif
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipv4_hdr_gen.sv
// Self-checking bench for ipv4_hdr_gen: a header-level reference model plus literal
// golden vectors. Honours IPV4_IDENT_INC_EN when it is defined for the build.
`timescale 1ns/1ps

module tb_ipv4_hdr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_ip = 32'd0;
    logic [31:0] dst_ip = 32'd0;
    logic [15:0] payload_len = 16'd0;
    logic        out_ready = 1'b1;
    logic [7:0]  out;
    logic        outclk;
    logic        busy;
    logic        done;

    ipv4_hdr_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_ip     (src_ip),
        .dst_ip     (dst_ip),
        .payload_len(payload_len),
        .out_ready  (out_ready),
        .out        (out),
        .outclk     (outclk),
        .busy       (busy),
        .done       (done)
    );

    localparam logic [31:0] GoldSrc = 32'hC0A80001;
    localparam logic [31:0] GoldDst = 32'hC0A800C7;

    logic [7:0] golden [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                                8'h40, 8'h11, 8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01,
                                8'hC0, 8'hA8, 8'h00, 8'hC7};

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  expq [$];
    logic [7:0]  cap [$];
    bit          mbusy = 1'b0;
    bit          exp_done = 1'b0;
    int          cyc = 0;
    int          st_cyc = 0;
    logic [15:0] mident = 16'd0;
    int          ndone = 0;
    bit          rdy_toggle = 1'b0;

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference header: assemble bytes, sum all words wide, fold afterwards, invert.
    function automatic void push_hdr(input logic [31:0] s, input logic [31:0] d,
                                     input logic [15:0] pl, input logic [15:0] id);
        logic [7:0]  b [20];
        logic [15:0] tl;
        logic [15:0] cs;
        logic [31:0] sum;
        tl    = pl + 16'd20;
        b[0]  = 8'h45;     b[1]  = 8'h00;
        b[2]  = tl[15:8];  b[3]  = tl[7:0];
        b[4]  = id[15:8];  b[5]  = id[7:0];
        b[6]  = 8'h40;     b[7]  = 8'h00;
        b[8]  = 8'd64;     b[9]  = 8'd17;
        b[10] = 8'h00;     b[11] = 8'h00;
        b[12] = s[31:24];  b[13] = s[23:16]; b[14] = s[15:8]; b[15] = s[7:0];
        b[16] = d[31:24];  b[17] = d[23:16]; b[18] = d[15:8]; b[19] = d[7:0];
        sum = 32'd0;
        for (int i = 0; i < 10; i++) sum = sum + {16'd0, b[2*i], b[2*i+1]};
        while (sum > 32'h0000FFFF) sum = {16'd0, sum[15:0]} + {16'd0, sum[31:16]};
        cs    = ~sum[15:0];
        b[10] = cs[15:8];
        b[11] = cs[7:0];
        for (int i = 0; i < 20; i++) expq.push_back(b[i]);
    endfunction

    // Compare process: checks every cycle's outputs against the model on the falling edge.
    always @(negedge clk) begin
        bit was_busy;
        bit emit;
        cyc++;
        if (!rst) begin
            chk("reset_outputs", 32'({out, outclk, busy, done}), 32'd0);
            expq.delete();
            mbusy    = 1'b0;
            exp_done = 1'b0;
            mident   = 16'd0;
        end else begin
            was_busy = mbusy;
            chk("busy", 32'(busy), 32'(mbusy));
            chk("done", 32'(done), 32'(exp_done));
            if (done) ndone++;
            exp_done = 1'b0;
            emit = mbusy && (cyc - st_cyc >= 11);
            chk("outclk", 32'(outclk), 32'(emit && out_ready));
            if (outclk && emit && expq.size() > 0) begin
                chk("out_byte", 32'(out), 32'(expq[0]));
                cap.push_back(out);
                void'(expq.pop_front());
                if (expq.size() == 0) begin
                    mbusy    = 1'b0;
                    exp_done = 1'b1;
`ifdef IPV4_IDENT_INC_EN
                    mident   = mident + 16'd1;
`endif
                end
            end
            if (start && !was_busy) begin
                push_hdr(src_ip, dst_ip, payload_len, mident);
                mbusy  = 1'b1;
                st_cyc = cyc;
            end
        end
    end

    // out_ready driver: steady high, or alternating 1/0 each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_toggle) out_ready = ~out_ready;
            else            out_ready = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] pl);
        src_ip      = s;
        dst_ip      = d;
        payload_len = pl;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic check_golden(input string tag);
        chk({tag, "_count"}, 32'(cap.size()), 32'd20);
        for (int i = 0; i < 20; i++) begin
            if (i < cap.size()) chk($sformatf("%s_b%0d", tag, i), 32'(cap[i]), 32'(golden[i]));
        end
    endtask

    initial begin
        int          nd;
        logic [15:0] lit_cs [3];
        logic [15:0] lit_id [3];
        bit          reached;

`ifdef IPV4_IDENT_INC_EN
        lit_cs = '{16'hB861, 16'hB860, 16'hB85F};
        lit_id = '{16'h0000, 16'h0001, 16'h0002};
`else
        lit_cs = '{16'hB861, 16'hB861, 16'hB861};
        lit_id = '{16'h0000, 16'h0000, 16'h0000};
`endif

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Golden header with out_ready held high.
        cap.delete();
        do_start(GoldSrc, GoldDst, 16'd95);
        wait_done();
        check_golden("golden");
        tick();

        // Same header with out_ready alternating.
        apply_reset();
        cap.delete();
        rdy_toggle = 1'b1;
        do_start(GoldSrc, GoldDst, 16'd95);
        wait_done();
        rdy_toggle = 1'b0;
        check_golden("toggle");
        tick();

        // Three back-to-back headers, each start issued in the previous done cycle.
        apply_reset();
        cap.delete();
        for (int k = 0; k < 3; k++) begin
            do_start(GoldSrc, GoldDst, 16'd95);
            wait_done();
        end
        chk("b2b_count", 32'(cap.size()), 32'd60);
        if (cap.size() == 60) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("b2b_ident%0d", k), 32'({cap[20*k+4], cap[20*k+5]}),
                    32'(lit_id[k]));
                chk($sformatf("b2b_csum%0d", k), 32'({cap[20*k+10], cap[20*k+11]}),
                    32'(lit_cs[k]));
            end
        end
        tick();

        // total_len wraps modulo 2^16.
        apply_reset();
        cap.delete();
        do_start(GoldSrc, GoldDst, 16'hFFF0);
        wait_done();
        chk("wrap_count", 32'(cap.size()), 32'd20);
        if (cap.size() == 20) begin
            chk("wrap_total_len", 32'({cap[2], cap[3]}), 32'h0004);
            chk("wrap_csum", 32'({cap[10], cap[11]}), 32'hB8D0);
        end
        tick();

        // Reset while byte 7 is on the bus aborts without done.
        apply_reset();
        cap.delete();
        do_start(GoldSrc, GoldDst, 16'd95);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cap.size() >= 7) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        chk("abort_reached_byte7", 32'(reached), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_out", 32'(out), 32'd0);
        chk("abort_outclk", 32'(outclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        nd = ndone;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("abort_no_done", 32'(ndone - nd), 32'd0);
        cap.delete();
        do_start(GoldSrc, GoldDst, 16'd95);
        wait_done();
        check_golden("after_abort");
        tick();

        // Starts during CALC and EMIT are ignored.
        apply_reset();
        cap.delete();
        nd = ndone;
        do_start(GoldSrc, GoldDst, 16'd95);
        repeat (3) tick();
        do_start(32'h0A000001, 32'h0A000002, 16'd5);
        for (int i = 0; i < 100; i++) begin
            if (cap.size() >= 5) break;
            tick();
        end
        do_start(32'h0A000003, 32'h0A000004, 16'd6);
        wait_done();
        repeat (15) tick();
        chk("ignored_starts_one_done", 32'(ndone - nd), 32'd1);
        check_golden("ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
